// File: rtl/comp_layer.sv
// -----------------------------------------------------------------------------
// comp_layer
//   Forward-path compare (argmax) stage. The dense layer's logits arrive as one
//   beat per vocabulary index, each beat carrying all N lanes in parallel. A
//   running maximum and its index are kept per lane. When the last vocabulary
//   index has been accepted, the winning indices are published on q and valid
//   pulses for one cycle.
//
// Ports
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   run      in   level, high while the forward controller sits in F_COMP
//   d_valid  in   logit beat valid
//   d        in   N*N_LEN logits, lane i at [i*N_LEN +: N_LEN], signed
//   d_ready  out  high in ACC; a beat is taken on d_valid & d_ready at posedge
//   valid    out  single-cycle completion pulse
//   q        out  N*CHAR_LEN argmax indices, lane i at [i*CHAR_LEN +: CHAR_LEN]
//
// Build option
//   COMP_PAD_MASK_EN : when defined, vocabulary index 0 (pad) can never win.
//                      The first beat seeds each lane with the most negative
//                      logit at index 1 instead of taking the beat's value.
// -----------------------------------------------------------------------------
module comp_layer #(
  parameter int N        = 10,
  parameter int CHAR_NUM = 200,
  parameter int CHAR_LEN = 8,
  parameter int N_LEN    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    run,
  input  logic                    d_valid,
  input  logic [N*N_LEN-1:0]      d,
  output logic                    d_ready,
  output logic                    valid,
  output logic [N*CHAR_LEN-1:0]   q
);

  localparam int CNT_W = (CHAR_NUM > 1) ? $clog2(CHAR_NUM) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } state_e;

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [N-1:0][N_LEN-1:0]     max_q, max_d;
  logic [N-1:0][CHAR_LEN-1:0]  idx_q, idx_d;
  logic [N*CHAR_LEN-1:0]       q_q, q_d;

  logic [N-1:0][N_LEN-1:0]     d_lane_s;
  logic                        abort_s;
  logic                        beat_s;
  logic                        last_s;

  assign d_lane_s = d;
  // A run drop in ACC wins over a coincident beat: the sequence is discarded.
  assign abort_s  = (state_q == ACC) && !run;
  assign beat_s   = (state_q == ACC) && run && d_valid;
  assign last_s   = beat_s && (cnt_q == CNT_W'(CHAR_NUM - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (run) state_d = ACC;
        else     state_d = IDLE;
      end
      ACC: begin
        if (!run)       state_d = IDLE;
        else if (last_s) state_d = DONE;
        else            state_d = ACC;
      end
      DONE: begin
        state_d = HOLD;
      end
      HOLD: begin
        // Wait for the controller to leave F_COMP so we do not retrigger.
        if (!run) state_d = IDLE;
        else      state_d = HOLD;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the state register.
  always_comb begin
    d_ready = 1'b0;
    valid   = 1'b0;
    case (state_q)
      IDLE:    begin d_ready = 1'b0; valid = 1'b0; end
      ACC:     begin d_ready = 1'b1; valid = 1'b0; end
      DONE:    begin d_ready = 1'b0; valid = 1'b1; end
      HOLD:    begin d_ready = 1'b0; valid = 1'b0; end
      default: begin d_ready = 1'b0; valid = 1'b0; end
    endcase
  end

  // Beat counter, per-lane running max/index and result capture.
  always_comb begin
    cnt_d = cnt_q;
    max_d = max_q;
    idx_d = idx_q;
    q_d   = q_q;
    if (abort_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (beat_s) begin
      for (int i = 0; i < N; i++) begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          // First beat seeds the lane; stale accumulators are simply overwritten.
`ifdef COMP_PAD_MASK_EN
          max_d[i] = {1'b1, {(N_LEN-1){1'b0}}};
          idx_d[i] = {{(CHAR_LEN-1){1'b0}}, 1'b1};
`else
          max_d[i] = d_lane_s[i];
          idx_d[i] = {CHAR_LEN{1'b0}};
`endif
        end else if ($signed(d_lane_s[i]) > $signed(max_q[i])) begin
          // Strict compare: on a tie the earlier (lower) index is kept.
          max_d[i] = d_lane_s[i];
          idx_d[i] = CHAR_LEN'(cnt_q);
        end else begin
          max_d[i] = max_q[i];
          idx_d[i] = idx_q[i];
        end
      end
      if (last_s) begin
        cnt_d = {CNT_W{1'b0}};
        q_d   = idx_d;
      end else begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else if (state_q == IDLE) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
      max_q <= '{default: {N_LEN{1'b0}}};
      idx_q <= '{default: {CHAR_LEN{1'b0}}};
      q_q   <= {(N*CHAR_LEN){1'b0}};
    end else begin
      cnt_q <= cnt_d;
      max_q <= max_d;
      idx_q <= idx_d;
      q_q   <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_comp_layer.sv
module tb_comp_layer;

  localparam int N        = 10;
  localparam int CHAR_NUM = 200;
  localparam int CHAR_LEN = 8;
  localparam int N_LEN    = 16;

  logic                  clk;
  logic                  rst_n;
  logic                  run;
  logic                  d_valid;
  logic [N*N_LEN-1:0]    d;
  logic                  d_ready;
  logic                  valid;
  logic [N*CHAR_LEN-1:0] q;

  comp_layer #(.N(N), .CHAR_NUM(CHAR_NUM), .CHAR_LEN(CHAR_LEN), .N_LEN(N_LEN)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .d_valid (d_valid),
    .d       (d),
    .d_ready (d_ready),
    .valid   (valid),
    .q       (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Expected outputs for the current cycle, set by the stimulus process
  logic                  chk_en    = 1'b0;
  logic                  exp_valid = 1'b0;
  logic                  exp_ready = 1'b0;
  logic [N*CHAR_LEN-1:0] exp_q     = '0;

  // Logit table of the sequence being streamed: lg[vocab index][lane]
  int lg [CHAR_NUM][N];

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Argmax per lane: find the largest value, then the lowest index holding it.
  function automatic logic [N*CHAR_LEN-1:0] model_q();
    logic [N*CHAR_LEN-1:0] r;
    int lo, mx, win;
    r = '0;
`ifdef COMP_PAD_MASK_EN
    lo = 1;
`else
    lo = 0;
`endif
    for (int i = 0; i < N; i++) begin
      mx = -32768;
      for (int j = lo; j < CHAR_NUM; j++) if (lg[j][i] > mx) mx = lg[j][i];
      win = -1;
      for (int j = lo; j < CHAR_NUM; j++) if (win < 0 && lg[j][i] == mx) win = j;
      r[i*CHAR_LEN +: CHAR_LEN] = CHAR_LEN'(win);
    end
    return r;
  endfunction

  function automatic int lane_q(input int i);
    logic [N*CHAR_LEN-1:0] t;
    t = q;
    return int'(t[i*CHAR_LEN +: CHAR_LEN]);
  endfunction

  // Per-cycle comparison of all outputs against the expectation
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid",   longint'(valid),   longint'(exp_valid));
      check("d_ready", longint'(d_ready), longint'(exp_ready));
      if (q !== exp_q) begin
        n_chk++;
        n_fail++;
        $display("FAIL q: got %h expected %h at %0t", q, exp_q, $time);
      end else begin
        n_chk++;
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int v);
    for (int j = 0; j < CHAR_NUM; j++)
      for (int i = 0; i < N; i++) lg[j][i] = v;
  endtask

  task automatic drive_beat(input int b);
    for (int i = 0; i < N; i++) d[i*N_LEN +: N_LEN] = N_LEN'(lg[b][i]);
  endtask

  // Stream one sequence. bubble: d_valid low every other cycle (d garbage then).
  // abort_after >= 0: drop run once that many beats were accepted.
  task automatic run_seq(input bit bubble, input int abort_after);
    int acc, cyc;
    run = 1'b1; d_valid = 1'b0; exp_valid = 1'b0; exp_ready = 1'b0;
    step();
    exp_ready = 1'b1;
    acc = 0; cyc = 0;
    while (acc < CHAR_NUM) begin
      if (abort_after >= 0 && acc == abort_after) begin
        run = 1'b0; d_valid = 1'b0;
        step();
        exp_ready = 1'b0;
        step();
        return;
      end
      if (bubble && (cyc % 2 == 1)) begin
        d_valid = 1'b0;
        d = {(N*N_LEN){1'b0}} | {N{16'h7fff}};
      end else begin
        d_valid = 1'b1;
        drive_beat(acc);
      end
      step();
      cyc++;
      if (d_valid) acc++;
    end
    d_valid = 1'b0;
    exp_valid = 1'b1; exp_ready = 1'b0; exp_q = model_q();
    step();
    exp_valid = 1'b0;
    repeat (4) step();   // run still high: no retrigger
    run = 1'b0;
    step();
    step();
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; d_valid = 1'b0; d = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_q",       longint'(q),       0);
    check("reset_valid",   longint'(valid),   0);
    check("reset_d_ready", longint'(d_ready), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    step();

    // A: full rate, lane i peak 100 at 3*i+5, rest -5
    fill(-5);
    for (int i = 0; i < N; i++) lg[3*i+5][i] = 100;
    run_seq(1'b0, -1);
    for (int i = 0; i < N; i++) check("A_lane_literal", longint'(lane_q(i)), longint'(3*i+5));

    // B: tie on lane 0, negative logits on lane 1, with bubbles
    fill(0);
    lg[7][0] = 50; lg[120][0] = 50;
    for (int j = 0; j < CHAR_NUM; j++) lg[j][1] = -300;
    lg[199][1] = -2;
    run_seq(1'b1, -1);
    check("B_tie_literal", longint'(lane_q(0)), 7);
    check("B_neg_literal", longint'(lane_q(1)), 199);

    // C: abort after 50 beats, q must keep B's result
    fill(20);
    run_seq(1'b0, 50);
    check("C_abort_keep", longint'(lane_q(1)), 199);

    // D: index 0 huge, index 9 second largest
    fill(0);
    for (int i = 0; i < N; i++) begin lg[0][i] = 1000; lg[9][i] = 10; end
    run_seq(1'b0, -1);
`ifdef COMP_PAD_MASK_EN
    for (int i = 0; i < N; i++) check("D_pad_literal", longint'(lane_q(i)), 9);
`else
    for (int i = 0; i < N; i++) check("D_nopad_literal", longint'(lane_q(i)), 0);
`endif

    // E: reset mid-ACC clears everything, then a clean sequence still works
    fill(1);
    run = 1'b1; step();
    exp_ready = 1'b1;
    d_valid = 1'b1; drive_beat(0);
    repeat (20) step();
    rst_n = 1'b0; run = 1'b0; d_valid = 1'b0;
    exp_ready = 1'b0; exp_q = '0;
    step();
    check("E_reset_q", longint'(q), 0);
    rst_n = 1'b1;
    step();
    fill(-5);
    for (int i = 0; i < N; i++) lg[3*i+5][i] = 100;
    run_seq(1'b0, -1);
    check("E_after_reset_lane9", longint'(lane_q(9)), 32);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/comp_layer.md
# comp_layer

Forward-path compare (argmax) stage for the F_COMP state. It consumes the dense layer's logits as a stream of beats, one beat per vocabulary index carrying all N positions in parallel. It tracks a running maximum per position and emits the N winning character indices as one packed word. That word becomes the source of the output AXI-Stream controller's data, replacing the loop-back of the input characters.

## Interface
Parameters:
- N, 10, characters per sequence (parallel lanes)
- CHAR_NUM, 200, vocabulary size (beats per sequence)
- CHAR_LEN, 8, character index width; must satisfy 2^CHAR_LEN >= CHAR_NUM
- N_LEN, 16, logit width, signed two's complement fixed-point

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  level; high while state_forward == F_COMP
- d_valid  in  1  logit beat valid
- d  in  N*N_LEN  logits for the current vocabulary index; lane i at [i*N_LEN +: N_LEN]
- d_ready  out  1  beat accepted when d_valid & d_ready at posedge
- valid  out  1  single-cycle done pulse; wired to state_forward_run in F_COMP
- q  out  N*CHAR_LEN  argmax index per lane; lane i at [i*CHAR_LEN +: CHAR_LEN]

## Operation
- States: IDLE, ACC, DONE, HOLD.
- IDLE: d_ready=0. The block goes to ACC on run=1. Beat counter cnt is cleared.
- ACC: d_ready=1.
  - Each accepted beat has vocabulary index cnt, and cnt then increments. The counter width is $clog2(CHAR_NUM).
  - Per lane, on the beat with cnt==0, the block loads max_i=d_i and idx_i=0 unconditionally.
  - Per lane, on later beats, the block loads max_i=d_i and idx_i=cnt only when d_i > max_i. The compare is signed and strict, so ties keep the lowest index.
  - When the beat with cnt==CHAR_NUM-1 is accepted, q is loaded with the idx values (including that beat's update), cnt returns to 0, and the state goes to DONE.
- DONE: valid=1 for exactly this cycle, d_ready=0. The state goes to HOLD unconditionally.
- HOLD: d_ready=0. The block waits for run=0, then goes to IDLE. This prevents a retrigger while the controller leaves F_COMP.
- Run deasserted while in ACC: abort to IDLE. No valid is produced, q is unchanged, and cnt is cleared.
- d_valid outside ACC is ignored. No beat is consumed.
- q holds its value from the last completed sequence until the next completion.
- max/idx accumulators are internal. They are not cleared between sequences, because the cnt==0 beat overwrites them.

## Timing
- Reset values: state=IDLE, d_ready=0, valid=0, q=0, cnt=0, accumulators 0.
- Reset asserted mid-ACC clears everything immediately. No valid is produced.
- run sampled high in IDLE gives d_ready=1 in the next cycle. There is one cycle of entry latency.
- With d_valid held high, CHAR_NUM beats take CHAR_NUM consecutive cycles. valid=1 in the cycle after the last beat is accepted, and q is already updated in that cycle.
- Bubbles (d_valid=0) stall cnt and the accumulators with no other effect.
- Total run-to-valid latency at full rate is CHAR_NUM+1 cycles after run is first sampled.
- Comparators are one level per lane and unregistered in front of the accumulator register. There is no pipelining.

## Configuration
- COMP_PAD_MASK_EN defined: vocabulary index 0 (pad character) is excluded.
  - The cnt==0 beat loads max_i to the most negative N_LEN value and idx_i to 1.
  - Index 0 can never win. If all of lanes 1..CHAR_NUM-1 equal the most negative value, idx_i stays 1.
- COMP_PAD_MASK_EN undefined: plain argmax over all indices as described in Operation.

## Test plan
- Reset with N=10, CHAR_NUM=200 -> q=0, valid=0, d_ready=0; run held high -> d_ready=1 one cycle later.
- Full-rate stream, lane i peak value 100 at index 3*i+5, all other logits -5 -> valid one cycle after beat 199; q lane i = 3*i+5.
- Tie: lane 0 value 50 at indices 7 and 120, all else 0 -> q lane 0 = 7 (lowest index wins).
- Negative logits: lane 1 all -300 except -2 at index 199 -> q lane 1 = 199 (signed compare).
- Bubbles: d_valid toggled every other cycle -> valid after exactly 200 accepted beats; run held high in HOLD -> no second valid until run drops and rises again.
- Abort: run dropped after 50 beats -> no valid, q keeps prior value; with COMP_PAD_MASK_EN, index 0 = 1000 and index 9 = 10 -> q = 9.
